data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder for the RV32I datapath; the memory-side end of the MemRead/MemWrite control produced by the main decoder.
- Accepts one load/store request at a time over a valid/ready handshake and applies RV32I byte, half and word semantics (little-endian).
- Inserts a programmable number of wait states, then returns a one-cycle response carrying ReadData and an Error flag.
- Sits between the execute stage (address from the ALU) and the register-file write-back mux.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; power of two.
- WAIT_CYCLES, 2, wait states between request acceptance and response; 0 is legal.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- ReqValid  input  1  request present this cycle.
- ReqReady  output  1  responder can accept a request.
- MemRead  input  1  load request; sampled on handshake.
- MemWrite  input  1  store request; sampled on handshake.
- Funct3  input  3  access size and signedness; sampled on handshake.
- Addr  input  32  byte address.
- WriteData  input  32  store data; low bytes are used for SB/SH.
- RespValid  output  1  one-cycle response pulse.
- ReadData  output  32  load result, extended to 32 bits; valid when RespValid is high.
- Error  output  1  request was rejected; valid when RespValid is high.

Behaviour:
- Reset:
  - Asynchronous, active-high; clk is the only clock.
  - Reset forces: state IDLE, wait counter 0, ReqReady=0, RespValid=0, ReadData=0, Error=0, captured request cleared.
  - Storage contents are not reset.
  - ReqReady rises at the first clk edge after reset deasserts.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: ReqReady=1. On ReqValid&&ReqReady, capture MemRead, MemWrite, Funct3, Addr and WriteData. Go to WAIT if WAIT_CYCLES>0, else go to RESP.
  - WAIT: ReqReady=0. The counter counts 1..WAIT_CYCLES; the FSM leaves WAIT on the edge where the count reaches WAIT_CYCLES.
  - RESP: RespValid=1, ReqReady=0 for exactly one cycle, then return to IDLE.
- Timing:
  - Handshake edge N gives RespValid high in cycle N+WAIT_CYCLES+1.
  - Back-to-back requests: one every WAIT_CYCLES+2 cycles.
  - Inputs are ignored outside IDLE.
  - ReqValid may drop without a handshake; nothing is captured.
- Decoding:
  - Loads: 000 LB (sign-extend), 001 LH (sign-extend), 010 LW, 100 LBU (zero-extend), 101 LHU (zero-extend).
  - Stores: 000 SB, 001 SH, 010 SW.
- Commit and read timing:
  - The store commits on the edge entering RESP and writes only the addressed byte lanes.
  - The load reads storage on the same edge. ReadData is registered, stays valid in RESP, and is held afterwards.
- Error=1 with no storage write when any of the following holds:
  - MemRead==MemWrite (both high or both low);
  - an illegal Funct3 for the access type;
  - word index Addr[31:2] >= DEPTH_WORDS;
  - a misaligned access (see Optional Feature).
- On error: ReadData=0.
- Reset asserted mid-operation: the pending access is abandoned, an uncommitted store is discarded, and no RespValid is produced.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - LH, LHU and SH with Addr[0]=1 give Error=1 with no access.
  - LW and SW with Addr[1:0]!=0 give Error=1 with no access.
- Undefined:
  - The low address bits are forced to alignment: Addr[0] is cleared for halfword accesses, Addr[1:0] for word accesses.
  - The access then proceeds with no error.

Decomposition:
- Package dm_pkg holds:
  - Funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state enum: IDLE, WAIT, RESP.
  - Byte-enable type logic [3:0].
- Sub-module dm_lane_align (combinational) produces:
  - the store byte-enable mask and the lane-shifted write data;
  - the load lane extraction and sign/zero extension.
- The FSM, counter and storage array stay in the top module.

Test Plan:
- SW Addr=0x10 WriteData=0xDEADBEEF, then LW Addr=0x10 -> ReadData=0xDEADBEEF, Error=0, RespValid exactly 3 cycles after each handshake (WAIT_CYCLES=2).
- After the above, LB Addr=0x13 -> 0xFFFFFFDE; LBU Addr=0x13 -> 0x000000DE; LH Addr=0x10 -> 0xFFFFBEEF; LHU Addr=0x12 -> 0x0000DEAD.
- SB Addr=0x11 WriteData=0x00000055, then LW Addr=0x10 -> 0xDEAD55EF (only byte lane 1 changed).
- Error responses, each with ReadData=0 and storage unchanged:
  - LW Addr=0x400 at DEPTH_WORDS=256;
  - MemRead=MemWrite=1;
  - Funct3=011 load.
- With MISALIGN_TRAP_EN: LW Addr=0x12 -> Error=1. Without it: the same request -> data from word 0x10, Error=0.
- Reset asserted in WAIT of SW Addr=0x20 WriteData=0x12345678:
  - no RespValid;
  - ReqReady=0 during reset and 1 one edge after release;
  - LW Addr=0x20 returns the pre-store value.
- WAIT_CYCLES=0 build: RespValid one cycle after the handshake; ReqReady low for exactly 1 cycle per request.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory responder.
//   - RV32I load/store Funct3 encodings
//   - responder FSM state type
//   - byte-enable type
//   - helper that tells whether a Funct3 is legal for a load or a store
package dm_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [3:0] be_t;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (is_load) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational byte-lane steering for RV32I little-endian
// loads and stores.
// Ports:
//   funct3      in   access size / signedness
//   addr_lo     in   low two address bits (already aligned by the caller
//                    when misaligned accesses are not trapped)
//   store_data  in   register store data (low bytes used for SB/SH)
//   load_word   in   full 32-bit word read from storage
//   byte_en     out  byte lanes a store writes
//   store_lanes out  store data replicated onto every candidate lane
//   load_data   out  extracted and sign/zero-extended load result
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output be_t         byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Shift the addressed byte/halfword down to bit 0.
    assign shifted = load_word >> {addr_lo, 3'b000};

    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = 32'h0;
        load_data   = 32'h0;
        case (funct3)
            F3_B: begin
                byte_en     = be_t'(4'b0001 << addr_lo);
                store_lanes = {4{store_data[7:0]}};
                load_data   = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                load_data   = {24'h0, shifted[7:0]};
            end
            F3_H: begin
                // Only lane pairs 0/1 and 2/3 are meaningful for halfwords.
                byte_en     = be_t'(4'b0011 << {addr_lo[1], 1'b0});
                store_lanes = {2{store_data[15:0]}};
                load_data   = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                load_data   = {16'h0, shifted[15:0]};
            end
            F3_W: begin
                byte_en     = 4'b1111;
                store_lanes = store_data;
                load_data   = load_word;
            end
            default: begin
                byte_en     = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: RV32I data memory with a valid/ready request port,
// programmable wait states and a one-cycle response pulse.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   ReqValid/ReqReady  request handshake
//   MemRead/MemWrite   access type (exactly one must be high)
//   Funct3             access size / signedness
//   Addr, WriteData    byte address and store data
//   RespValid          one-cycle response pulse
//   ReadData, Error    response payload, valid while RespValid is high
// Build option: define MISALIGN_TRAP_EN to reject misaligned halfword/word
// accesses; otherwise the low address bits are forced to alignment.
module data_mem_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        Error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST   = CW'(WAIT_CYCLES);
    localparam logic [29:0]   DEPTH_LIMIT = 30'(DEPTH_WORDS);

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            ready_reg, ready_next;
    logic            handshake, enter_resp, resp_valid;

    logic            rd_reg, wr_reg;
    logic [2:0]      f3_reg;
    logic [31:0]     addr_reg, wdata_reg;
    logic [31:0]     rdata_reg;
    logic            err_reg;

    // Request seen by the access logic: the live inputs while idle (needed
    // when there are no wait states and the access happens on the handshake
    // edge itself), the captured copy otherwise.
    logic            req_rd, req_wr;
    logic [2:0]      req_f3;
    logic [31:0]     req_addr, req_wdata;
    logic [31:0]     eff_addr;
    logic            misalign, req_err, commit;
    logic [AW-1:0]   word_idx;
    logic [31:0]     mem_word;

    be_t             byte_en;
    logic [31:0]     store_lanes, load_data;

    logic [31:0]     mem [DEPTH_WORDS];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ready_reg <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        handshake  = 1'b0;
        enter_resp = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ReqValid && ready_reg) begin
                    handshake = 1'b1;
                    cnt_next  = '0;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_next == WAIT_LAST) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                    cnt_next   = '0;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // Registered ready keeps ReqReady low through reset and raises it on
        // the first edge after release.
        ready_next = (state_next == IDLE);
    end

    // ---------------- request capture and response registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            f3_reg    <= 3'b000;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            rdata_reg <= 32'h0;
            err_reg   <= 1'b0;
        end else begin
            if (handshake) begin
                rd_reg    <= MemRead;
                wr_reg    <= MemWrite;
                f3_reg    <= Funct3;
                addr_reg  <= Addr;
                wdata_reg <= WriteData;
            end
            if (enter_resp) begin
                err_reg   <= req_err;
                rdata_reg <= (req_err || !req_rd) ? 32'h0 : load_data;
            end
        end
    end

    // ---------------- decode ----------------
    always_comb begin
        if (state_reg == IDLE) begin
            req_rd    = MemRead;
            req_wr    = MemWrite;
            req_f3    = Funct3;
            req_addr  = Addr;
            req_wdata = WriteData;
        end else begin
            req_rd    = rd_reg;
            req_wr    = wr_reg;
            req_f3    = f3_reg;
            req_addr  = addr_reg;
            req_wdata = wdata_reg;
        end

        eff_addr = req_addr;
`ifdef MISALIGN_TRAP_EN
        misalign = (((req_f3 == F3_H) || (req_f3 == F3_HU)) && req_addr[0]) ||
                   ((req_f3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
        if ((req_f3 == F3_H) || (req_f3 == F3_HU)) begin
            eff_addr[0] = 1'b0;
        end else if (req_f3 == F3_W) begin
            eff_addr[1:0] = 2'b00;
        end
`endif

        req_err = (req_rd == req_wr) ||
                  !f3_legal(req_rd, req_f3) ||
                  (eff_addr[31:2] >= DEPTH_LIMIT) ||
                  misalign;
    end

    assign word_idx = eff_addr[AW+1:2];
    assign mem_word = mem[word_idx];
    // An active reset abandons the access, so a pending store never lands.
    assign commit   = enter_resp && req_wr && !req_err && !reset;

    dm_lane_align u_lane_align (
        .funct3      (req_f3),
        .addr_lo     (eff_addr[1:0]),
        .store_data  (req_wdata),
        .load_word   (mem_word),
        .byte_en     (byte_en),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= store_lanes[i*8 +: 8];
                end
            end
        end
    end

    assign ReqReady  = ready_reg;
    assign RespValid = resp_valid;
    assign ReadData  = rdata_reg;
    assign Error     = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    parameter int WAIT_CYCLES = 2;

    logic        clk;
    logic        reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        RespValid;
    logic [31:0] ReadData;
    logic        Error;

    int checks;
    int errors;

    data_mem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .Addr      (Addr),
        .WriteData (WriteData),
        .RespValid (RespValid),
        .ReadData  (ReadData),
        .Error     (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_data;
        logic        chk_data;
        string       name;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

`ifdef MISALIGN_TRAP_EN
    localparam logic        MIS_ERR   = 1'b1;
    localparam logic [31:0] MIS_LW    = 32'h0;
    localparam logic [31:0] AFTER_SH  = 32'hDEAD55EF;
`else
    localparam logic        MIS_ERR   = 1'b0;
    localparam logic [31:0] MIS_LW    = 32'hDEAD55EF;
    localparam logic [31:0] AFTER_SH  = 32'hAAAA55EF;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and follow it through to its response.
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output int low_cnt,
                          output logic e, output logic [31:0] d,
                          output logic ready_after, output logic resp_after);
        int guard;
        ReqValid  = 1'b1;
        MemRead   = rd;
        MemWrite  = wr;
        Funct3    = f3;
        Addr      = a;
        WriteData = wd;
        guard = 0;
        while (!ReqReady && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        // Drive a conflicting store while busy: it must be ignored.
        ReqValid  = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        Funct3    = 3'b010;
        Addr      = 32'h10;
        WriteData = 32'hFFFFFFFF;
        lat     = 0;
        low_cnt = (!ReqReady) ? 1 : 0;
        while (!RespValid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (!ReqReady) low_cnt++;
        end
        ReqValid = 1'b0;
        if (!RespValid) lat = -1;
        e = Error;
        d = ReadData;
        @(posedge clk); #1;
        ready_after = ReqReady;
        resp_after  = RespValid;
    endtask

    initial begin
        int          lat, low_cnt;
        logic        e, ra, rva;
        logic [31:0] d;

        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0, "sw_10"};
        vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1, "lw_10"};
        vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFFDE, 1'b1, "lb_13"};
        vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h000000DE, 1'b1, "lbu_13"};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h10,  32'h0,        1'b0, 32'hFFFFBEEF, 1'b1, "lh_10"};
        vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h12,  32'h0,        1'b0, 32'h0000DEAD, 1'b1, "lhu_12"};
        vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h11,  32'h00000055, 1'b0, 32'h0,        1'b0, "sb_11"};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEAD55EF, 1'b1, "lw_after_sb"};
        vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h400, 32'h0,        1'b1, 32'h0,        1'b1, "lw_range"};
        vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h10,  32'h0,        1'b1, 32'h0,        1'b1, "rd_and_wr"};
        vecs[10] = '{1'b1, 1'b0, 3'b011, 32'h10,  32'h0,        1'b1, 32'h0,        1'b1, "load_f3_011"};
        vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h10,  32'h0,        1'b1, 32'h0,        1'b1, "store_f3_100"};
        vecs[12] = '{1'b0, 1'b0, 3'b010, 32'h10,  32'h0,        1'b1, 32'h0,        1'b1, "neither"};
        vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEAD55EF, 1'b1, "lw_unchanged"};
        vecs[14] = '{1'b1, 1'b0, 3'b010, 32'h12,  32'h0,        MIS_ERR, MIS_LW,    1'b1, "lw_12_misalign"};
        vecs[15] = '{1'b0, 1'b1, 3'b001, 32'h13,  32'h0000AAAA, MIS_ERR, 32'h0,     1'b0, "sh_13_misalign"};
        vecs[16] = '{1'b1, 1'b0, 3'b010, 32'h10,  32'h0,        1'b0, AFTER_SH,     1'b1, "lw_after_sh"};
        vecs[17] = '{1'b0, 1'b1, 3'b000, 32'h3FF, 32'h00000080, 1'b0, 32'h0,        1'b0, "sb_last"};
        vecs[18] = '{1'b1, 1'b0, 3'b000, 32'h3FF, 32'h0,        1'b0, 32'hFFFFFF80, 1'b1, "lb_last"};
        vecs[19] = '{1'b0, 1'b1, 3'b001, 32'h402, 32'h1234,     1'b1, 32'h0,        1'b0, "sh_range"};

        reset     = 1'b1;
        ReqValid  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        Addr      = 32'h0;
        WriteData = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ReqReady), 32'd0);
        chk("reset_resp",  32'(RespValid), 32'd0);
        chk("reset_rdata", ReadData, 32'h0);
        chk("reset_error", 32'(Error), 32'd0);
        reset = 1'b0;
        chk("ready_before_edge", 32'(ReqReady), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'(ReqReady), 32'd1);

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd,
                   lat, low_cnt, e, d, ra, rva);
            chk({vecs[i].name, "_latency"},  32'(lat), 32'(WAIT_CYCLES));
            chk({vecs[i].name, "_error"},    32'(e), 32'(vecs[i].exp_err));
            if (vecs[i].chk_data) chk({vecs[i].name, "_rdata"}, d, vecs[i].exp_data);
            chk({vecs[i].name, "_ready_low"}, 32'(low_cnt), 32'(WAIT_CYCLES + 1));
            chk({vecs[i].name, "_ready_back"}, 32'(ra), 32'd1);
            chk({vecs[i].name, "_pulse_end"}, 32'(rva), 32'd0);
            $display("txn %0d %s rd=%b wr=%b f3=%b addr=%h wd=%h -> err=%b data=%h lat=%0d",
                     i, vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr,
                     vecs[i].wd, e, d, lat);
        end

        // Reset during the wait of a store: the store must be discarded.
        do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, lat, low_cnt, e, d, ra, rva);
        chk("prestore_error", 32'(e), 32'd0);
        $display("txn prestore sw addr=00000020 wd=0badf00d -> err=%b", e);

        ReqValid  = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        Funct3    = 3'b010;
        Addr      = 32'h20;
        WriteData = 32'h12345678;
        for (int g = 0; g < 50 && !ReqReady; g++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        ReqValid = 1'b0;
        if (WAIT_CYCLES > 0) begin
            reset = 1'b1;
            #1;
            chk("midreset_ready", 32'(ReqReady), 32'd0);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                chk("midreset_no_resp", 32'(RespValid), 32'd0);
                chk("midreset_ready_hold", 32'(ReqReady), 32'd0);
            end
            reset = 1'b0;
            chk("midreset_resp_release", 32'(RespValid), 32'd0);
            @(posedge clk); #1;
            chk("midreset_ready_back", 32'(ReqReady), 32'd1);
            chk("midreset_no_resp_after", 32'(RespValid), 32'd0);
            $display("txn midreset sw addr=00000020 wd=12345678 abandoned");
            do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, lat, low_cnt, e, d, ra, rva);
            chk("midreset_lw_rdata", d, 32'h0BADF00D);
            chk("midreset_lw_error", 32'(e), 32'd0);
            $display("txn lw addr=00000020 -> err=%b data=%h", e, d);
        end else begin
            // No wait state to interrupt: the store lands immediately.
            for (int g = 0; g < 5 && !ReqReady; g++) begin
                @(posedge clk); #1;
            end
            do_req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, lat, low_cnt, e, d, ra, rva);
            chk("w0_lw_rdata", d, 32'h12345678);
            $display("txn lw addr=00000020 -> err=%b data=%h", e, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
